// File: rtl/greyscale_pkg.sv
// greyscale_pkg: mode and state types shared by the greyscale binning stage
package greyscale_pkg;

    typedef enum logic [1:0] {
        GM_AVG4  = 2'd0,
        GM_GREEN = 2'd1,
        GM_PASS  = 2'd2,
        GM_RSVD  = 2'd3
    } grey_mode_e;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } gs_state_e;

endpackage

// File: rtl/greyscale_bin_line_buffer.sv
// line_buffer: single-port read-before-write circular line store with a 1-cycle read
//  iCLK/iRST clock and sync active-high reset (pointer and read register only)
//  wr_en     advance: write wr_data at the pointer, latch the old word onto rd_data
//  rd_data   word written DEPTH enables earlier; frozen while wr_en is low
module line_buffer #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 1280
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    always_ff @(posedge iCLK) begin
        if (wr_en)
            mem[ptr] <= wr_data;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ptr     <= '0;
            rd_data <= '0;
        end else if (wr_en) begin
            rd_data <= mem[ptr];
            ptr     <= ptr == AW'(DEPTH - 1) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/greyscale_bin.sv
// greyscale_bin: Bayer-to-greyscale 2x2 window stage with optional 2x2 decimation
//  iCLK/iRST           clock, sync active-high reset
//  iMODE/iDECIM        grey mode and decimation, captured on the start-of-frame pixel
//  iX_Cont/iY_Cont     input coordinates, iDATA raw pixel, iDVAL input valid
//  oX_Cont/oY_Cont     output coordinates, oDATA grey pixel, oDVAL output valid (2 cycles later)
module greyscale_bin
    import greyscale_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int LINE_W = 1280,
    parameter int CNT_W  = 11
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [1:0]        iMODE,
    input  logic              iDECIM,
    input  logic [CNT_W-1:0]  iX_Cont,
    input  logic [CNT_W-1:0]  iY_Cont,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    output logic [DATA_W-1:0] oDATA,
    output logic [CNT_W-1:0]  oX_Cont,
    output logic [CNT_W-1:0]  oY_Cont,
    output logic              oDVAL
);

    gs_state_e         state, state_nx;
    grey_mode_e        mode_q;
    logic              decim_q;
    logic              sof, act;
    logic [DATA_W-1:0] cur, left, up, ul, res;
    logic [CNT_W-1:0]  x1, y1;
    logic              v1, emit, x_nz, y_nz;
    logic [DATA_W+1:0] c_w, l_w, u_w, ul_w, s4, s_cl, s_cu, s_cul, s_lu;

    assign sof = iDVAL && iX_Cont == '0 && iY_Cont == '0;

    always_comb begin
        state_nx = state;
        act      = 1'b0;
        if (state == WAIT_SOF) begin
            state_nx = sof ? RUN : WAIT_SOF;
            act      = sof;
        end else begin
            act = iDVAL;
        end
    end

    always_ff @(posedge iCLK) begin
        state <= iRST ? WAIT_SOF : state_nx;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mode_q  <= GM_AVG4;
            decim_q <= 1'b0;
        end else if (sof) begin
            mode_q  <= grey_mode_e'(iMODE);
            decim_q <= iDECIM;
        end
    end

    // The buffer's read register is the "up" tap of the window.
    line_buffer #(
        .WIDTH(DATA_W),
        .DEPTH(LINE_W)
    ) u_line_buffer (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .wr_en  (act),
        .wr_data(iDATA),
        .rd_data(up)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cur  <= '0;
            left <= '0;
            ul   <= '0;
            x1   <= '0;
            y1   <= '0;
            v1   <= 1'b0;
        end else begin
            v1 <= act;
            if (act) begin
                cur  <= iDATA;
                left <= cur;
                ul   <= up;
                x1   <= iX_Cont;
                y1   <= iY_Cont;
            end
        end
    end

    assign c_w   = {2'b00, cur};
    assign l_w   = {2'b00, left};
    assign u_w   = {2'b00, up};
    assign ul_w  = {2'b00, ul};
    assign s4    = c_w + l_w + u_w + ul_w;
    assign s_cl  = c_w + l_w;
    assign s_cu  = c_w + u_w;
    assign s_cul = c_w + ul_w;
    assign s_lu  = l_w + u_w;
    assign x_nz  = x1 != '0;
    assign y_nz  = y1 != '0;

    // Edge pixels fall back to the neighbours that exist in the frame.
    always_comb begin
        res = cur;
        if (mode_q == GM_AVG4)
            res = x_nz && y_nz ? DATA_W'(s4 >> 2) :
                  x_nz         ? DATA_W'(s_cl >> 1) :
                  y_nz         ? DATA_W'(s_cu >> 1) : cur;
        else if (mode_q == GM_GREEN)
            res = !(x_nz && y_nz) ? cur :
                  x1[0] == y1[0]  ? DATA_W'(s_cul >> 1) : DATA_W'(s_lu >> 1);
    end

    // With decimation only the bottom-right pixel of each quad carries the full window.
    assign emit = v1 && (!decim_q || (x1[0] && y1[0]));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDATA   <= '0;
            oX_Cont <= '0;
            oY_Cont <= '0;
            oDVAL   <= 1'b0;
        end else begin
            oDVAL <= emit;
            if (emit) begin
                oDATA   <= res;
                oX_Cont <= decim_q ? x1 >> 1 : x1;
                oY_Cont <= decim_q ? y1 >> 1 : y1;
            end
        end
    end

endmodule

// File: tb/tb_greyscale_bin.sv
// tb_greyscale_bin: randomized scoreboard bench for greyscale_bin against a frame-level model
module tb_greyscale_bin;

    localparam int DW = 12;
    localparam int LW = 4;
    localparam int CW = 11;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic [1:0]    iMODE;
    logic          iDECIM;
    logic [CW-1:0] iX_Cont, iY_Cont;
    logic [DW-1:0] iDATA;
    logic          iDVAL;
    logic [DW-1:0] oDATA;
    logic [CW-1:0] oX_Cont, oY_Cont;
    logic          oDVAL;

    greyscale_bin #(.DATA_W(DW), .LINE_W(LW), .CNT_W(CW)) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iMODE  (iMODE),
        .iDECIM (iDECIM),
        .iX_Cont(iX_Cont),
        .iY_Cont(iY_Cont),
        .iDATA  (iDATA),
        .iDVAL  (iDVAL),
        .oDATA  (oDATA),
        .oX_Cont(oX_Cont),
        .oY_Cont(oY_Cont),
        .oDVAL  (oDVAL)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int data;
        int x;
        int y;
        int due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   img[32][LW];
    int   pat[32][LW];
    bit   run = 1'b0;
    int   m_mode = 0;
    bit   m_decim = 1'b0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Grey value of pixel (x,y) from the frame seen so far, using the mode captured at SOF.
    function automatic int grey(int x, int y);
        int c, l, u, d;
        c = img[y][x];
        l = x > 0 ? img[y][x-1] : 0;
        u = y > 0 ? img[y-1][x] : 0;
        d = (x > 0 && y > 0) ? img[y-1][x-1] : 0;
        if (m_mode == 0)
            return (x > 0 && y > 0) ? (c + l + u + d) / 4 :
                   x > 0 ? (c + l) / 2 : y > 0 ? (c + u) / 2 : c;
        if (m_mode == 1)
            return (x > 0 && y > 0) ? (((x % 2) == (y % 2)) ? (c + d) / 2 : (l + u) / 2) : c;
        return c;
    endfunction

    always @(negedge iCLK) begin
        exp_t e;
        if (oDVAL) begin
            if (q.size() == 0) begin
                check("unexpected_dval", 1, 0);
            end else begin
                e = q.pop_front();
                check("data", int'(oDATA), e.data);
                check("x", int'(oX_Cont), e.x);
                check("y", int'(oY_Cont), e.y);
                check("latency_cycle", cyc, e.due);
            end
        end
    end

    task automatic pixel(int x, int y, int d, bit v);
        @(posedge iCLK);
        #1;
        iX_Cont = CW'(x);
        iY_Cont = CW'(y);
        iDATA   = DW'(d);
        iDVAL   = v;
        if (v) begin
            if (x == 0 && y == 0) begin
                run     = 1'b1;
                m_mode  = int'(iMODE);
                m_decim = iDECIM;
            end
            if (run) begin
                img[y][x] = d;
                if (!m_decim || (x % 2 == 1 && y % 2 == 1))
                    q.push_back('{grey(x, y), m_decim ? x / 2 : x, m_decim ? y / 2 : y, cyc + 2});
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            pixel($urandom_range(3), $urandom_range(3), $urandom_range(4095), 1'b0);
    endtask

    task automatic do_reset();
        @(posedge iCLK);
        #1;
        iRST  = 1'b1;
        iDVAL = 1'b0;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        run  = 1'b0;
        q.delete();
    endtask

    // gaps: 0 none, 1 strict 1/0 toggle, 2 random; chg forces PASS+decim mid-frame; stop < 0 sends all
    task automatic send_frame(int rows, int mode, bit decim, int gaps, bit chg, int stop);
        int n;
        n = 0;
        iMODE  = 2'(mode);
        iDECIM = decim;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < LW; x++) begin
                if (n == stop) return;
                pixel(x, y, pat[y][x], 1'b1);
                n++;
                if (chg && n == 2) begin
                    iMODE  = 2'd2;
                    iDECIM = 1'b1;
                end
                if (gaps == 1 || (gaps == 2 && $urandom_range(3) == 0))
                    idle(gaps == 1 ? 1 : $urandom_range(1, 3));
            end
        end
    endtask

    task automatic fill_random();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < LW; x++)
                pat[y][x] = $urandom_range(7) == 0 ? 4095 : $urandom_range(4095);
    endtask

    task automatic fill_s1();
        for (int x = 0; x < LW; x++) begin
            pat[0][x] = 4 * (x + 1);
            pat[1][x] = 20 + 4 * x;
        end
    endtask

    initial begin
        iRST = 1'b1; iDVAL = 1'b0; iMODE = 2'd0; iDECIM = 1'b0;
        iX_Cont = '0; iY_Cont = '0; iDATA = '0;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_odval", int'(oDVAL), 0);
        check("rst_odata", int'(oDATA), 0);
        check("rst_ox", int'(oX_Cont), 0);
        check("rst_oy", int'(oY_Cont), 0);
        iRST = 1'b0;
        pixel(1, 0, 5, 1'b1);
        pixel(2, 0, 6, 1'b1);
        idle(3);
        fill_s1();
        send_frame(2, 0, 1'b0, 0, 1'b0, -1);
        idle(3);
        send_frame(2, 0, 1'b0, 1, 1'b0, -1);
        idle(3);
        pat[0][0] = 200; pat[0][1] = 30; pat[0][2] = 7;  pat[0][3] = 9;
        pat[1][0] = 10;  pat[1][1] = 100; pat[1][2] = 55; pat[1][3] = 77;
        send_frame(2, 1, 1'b0, 0, 1'b0, -1);
        idle(2);
        fill_random();
        send_frame(2, 0, 1'b1, 0, 1'b0, -1);
        idle(2);
        fill_random();
        send_frame(2, 0, 1'b0, 0, 1'b1, -1);
        fill_random();
        send_frame(2, 2, 1'b0, 0, 1'b0, -1);
        idle(2);
        fill_s1();
        send_frame(2, 0, 1'b0, 0, 1'b0, 6);
        do_reset();
        pixel(2, 1, 28, 1'b1);
        pixel(3, 1, 32, 1'b1);
        idle(2);
        send_frame(2, 0, 1'b0, 0, 1'b0, -1);
        for (int f = 0; f < 20; f++) begin
            fill_random();
            send_frame($urandom_range(2, 6), $urandom_range(3), 1'($urandom_range(1)),
                       $urandom_range(2), 1'($urandom_range(3) == 0), -1);
            idle($urandom_range(2));
        end
        idle(5);
        check("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
